xs3_decoder: RTL and testbench
==============================

# xs3_decoder

Sequential excess-3 to BCD/binary decoder, the receive-side counterpart of the team's 4-bit BCD-to-excess-3 code converter. It accepts one excess-3 digit per valid/ready handshake and strips the +3 bias. It flags illegal codes and assembles up to DIGITS digits into one frame. Each completed frame is presented as a packed BCD word plus its binary value on a valid/ready output port. It sits between a serial excess-3 digit source and downstream arithmetic or display logic.

## Interface
- DIGITS, 4: maximum digits per frame (1–8).
- BIN_W, 14: binary output width; must be ≥ ceil(log2(10^DIGITS)). 14 covers 9999.
- CNT_W, 3: digit-count width; must be ≥ ceil(log2(DIGITS+1)).
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_code and in_last are valid this cycle.
- in_ready  output  1  decoder can accept a digit.
- in_code  input  4  excess-3 digit; bit 3 is MSB (converter output e), bit 0 is LSB (h).
- in_last  input  1  this digit closes the frame.
- out_valid  output  1  frame result is available.
- out_ready  input  1  consumer takes the result.
- out_bcd  output  4*DIGITS  packed BCD, most recent digit in [3:0], unused upper nibbles 0.
- out_bin  output  BIN_W  binary value of the frame.
- out_count  output  CNT_W  number of digits in the frame (1..DIGITS).
- out_err  output  1  at least one illegal code occurred in the frame.

## Operation
- Two states: ACC (collecting) and OUT (holding the result). in_ready = (state==ACC), registered. out_valid = (state==OUT).
- Accept occurs when in_valid && in_ready. in_code and in_last are ignored otherwise.
- Legal codes are 0x3..0xC; digit = in_code − 3 (0..9).
- Illegal codes are 0x0–0x2 and 0xD–0xF. The digit is taken as 0, the sticky err bit is set for the frame, and the count still increments.
- On each accept:
  - bcd ← {bcd[4*DIGITS-5:0], digit}
  - bin ← (bin<<3) + (bin<<1) + digit, truncated to BIN_W
  - cnt ← cnt + 1
- Frame closes on an accept where in_last=1, or where cnt+1 == DIGITS (auto-close; in_last is irrelevant). On close, state goes to OUT.
- In OUT, outputs are stable and in_ready=0. On out_valid && out_ready, bcd, bin, cnt and err clear and state returns to ACC.
- Reset (rst_n low at a clock edge):
  - state=ACC, all accumulators 0.
  - Outputs: in_ready=0, out_valid=0, out_bcd=0, out_bin=0, out_count=0, out_err=0.
  - in_ready rises on the first edge with rst_n=1.
  - A partial frame or pending result is discarded.

## Timing
- Latency: close-accept at edge k → out_valid=1 after edge k; results are registered, with no combinational input-to-output path.
- Output handshake at edge m → out_valid=0 and in_ready=1 after edge m. There is no same-cycle bypass, so the next digit is accepted no earlier than edge m+1.
- Throughput: an n-digit frame with out_ready held high takes n+1 cycles.
- in_ready is 0 throughout OUT. An in_valid asserted during OUT is not consumed; the source must hold its digit until in_ready=1.
- out_* hold their values from OUT entry until the handshake, including through any out_ready=0 stretch.
- An accept of a digit and an out handshake can never coincide, because the states are exclusive.
- bin arithmetic is unsigned. With legal widths there is no overflow. If BIN_W is undersized, the result wraps modulo 2^BIN_W and no flag is raised.

## Test plan
- Input codes 0x4, 0x5, 0x6 with in_last on the third, out_ready=1 → out_bcd=0x0123, out_bin=123, out_count=3, out_err=0. out_valid is high for exactly 1 cycle, one cycle after the third accept.
- Input codes 0xC ×4 with in_last=0 throughout → auto-close with out_bcd=0x9999, out_bin=9999, out_count=4. A fifth code 0x3 presented immediately afterwards is accepted only after the handshake and starts a new frame.
- Input codes 0x7, 0xF, 0x3 with last on the third → out_bcd=0x0400, out_bin=400, out_count=3, out_err=1. The next frame, single code 0x8 with last → out_bcd=0x0005, out_bin=5, out_err=0 (the err bit is cleared between frames).
- Backpressure: close a frame (0x4 with last), hold out_ready=0 for 5 cycles while in_valid=1, in_code=0x9 → in_ready=0 and outputs stay at bcd=0x0001, bin=1 throughout. After out_ready=1, 0x9 is accepted as digit 6 of a new frame.
- Reset mid-frame: accept 0x5, 0x6, then drive rst_n=0 for 1 cycle → all outputs 0. The next frame, 0x3 with last, gives out_bcd=0x0000, out_bin=0, out_count=1.
- Reset while in OUT with out_ready=0 → out_valid drops after the reset edge, in_ready=0 during reset and 1 on the edge after rst_n returns high.

Source files
------------

// File: rtl/xs3_decoder.sv
// Excess-3 digit stream decoder: strips the +3 bias, flags illegal codes and
// assembles up to DIGITS digits into one packed-BCD / binary frame result.
module xs3_decoder #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14,
  parameter int CNT_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_code,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [BIN_W-1:0]      out_bin,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_err
);

  typedef enum logic {ACC = 1'b0, OUT = 1'b1} state_t;

  state_t                state_q;
  logic                  in_ready_q;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q;
  logic [3:0]            digit_d;
  logic                  illegal_d;
  logic                  close_d;
  logic                  accept;

  function automatic logic xs3_legal(input logic [3:0] c);
    return (c >= 4'd3) && (c <= 4'd12);
  endfunction

  function automatic logic [3:0] xs3_digit(input logic [3:0] c);
    return xs3_legal(c) ? (c - 4'd3) : 4'd0;
  endfunction

  assign accept = in_valid && in_ready_q;

  always_comb begin
    digit_d   = xs3_digit(in_code);
    illegal_d = !xs3_legal(in_code);
    bcd_d     = bcd_q << 4;
    bcd_d[3:0] = digit_d;
    // bin*10 + digit, wrapping modulo 2^BIN_W when undersized
    bin_d     = (bin_q << 3) + (bin_q << 1) + BIN_W'(digit_d);
    cnt_d     = cnt_q + CNT_W'(1);
    close_d   = in_last || (cnt_d == CNT_W'(DIGITS));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ACC;
      in_ready_q <= 1'b0;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            bcd_q <= bcd_d;
            bin_q <= bin_d;
            cnt_q <= cnt_d;
            err_q <= err_q | illegal_d;
            if (close_d) begin
              state_q    <= OUT;
              in_ready_q <= 1'b0;
            end
          end
        end
        OUT: begin
          in_ready_q <= 1'b0;
          if (out_ready) begin
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            state_q    <= ACC;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ACC;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == OUT);
  assign out_bcd   = bcd_q;
  assign out_bin   = bin_q;
  assign out_count = cnt_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_xs3_decoder.sv
// Bench for xs3_decoder: frame table, hand-written handshake/reset sequences
// and a randomized run against a digit-list reference model.
module tb_xs3_decoder;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int CNT_W  = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [3:0]          in_code;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] out_bcd;
  logic [BIN_W-1:0]    out_bin;
  logic [CNT_W-1:0]    out_count;
  logic                out_err;

  int total = 0;
  int bad   = 0;

  xs3_decoder #(.DIGITS(DIGITS), .BIN_W(BIN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_bin(out_bin), .out_count(out_count), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] codes;   // code j in nibble j
    int          n;
    logic        last_end;
    logic [15:0] bcd;
    int          bin;
    int          cnt;
    logic        err;
  } frame_t;

  frame_t tbl[7];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present a digit, wait (bounded) for in_ready, then let it be accepted
  task automatic send(input logic [3:0] code, input logic last);
    int n;
    in_valid = 1'b1;
    in_code  = code;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [15:0] b, input int bin,
                            input int cnt, input logic err);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_bcd"},   out_bcd,   b);
    chk({tag, "_bin"},   out_bin,   bin);
    chk({tag, "_cnt"},   out_count, cnt);
    chk({tag, "_err"},   out_err,   err);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, out_valid, 0);
    chk({tag, "_hs_ready"}, in_ready, 1);
  endtask

  // reference model state: digits of the current frame plus sticky error
  int   m_digits[$];
  logic m_err, m_acc, m_rdy;

  function automatic longint m_bcd();
    longint v = 0;
    int n = m_digits.size();
    for (int i = 0; i < n; i++) v += longint'(m_digits[i]) * (longint'(1) << (4 * (n - 1 - i)));
    return v;
  endfunction

  function automatic longint m_bin();
    longint v = 0, p = 1;
    for (int i = m_digits.size() - 1; i >= 0; i--) begin
      v += m_digits[i] * p;
      p *= 10;
    end
    return v % (longint'(1) << BIN_W);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_code = 4'h0; in_last = 1'b0; out_ready = 1'b0;

    // reset state
    step(); step();
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_bcd", out_bcd, 0);
    chk("rst_bin", out_bin, 0);
    chk("rst_cnt", out_count, 0);
    chk("rst_err", out_err, 0);
    rst_n = 1'b1;
    step();
    chk("rst_rel_ready", in_ready, 1);

    // frame table with out_ready held high
    tbl[0] = '{16'h0654, 3, 1'b1, 16'h0123,  123, 3, 1'b0};
    tbl[1] = '{16'hCCCC, 4, 1'b0, 16'h9999, 9999, 4, 1'b0};
    tbl[2] = '{16'h03F7, 3, 1'b1, 16'h0400,  400, 3, 1'b1};
    tbl[3] = '{16'h0008, 1, 1'b1, 16'h0005,    5, 1, 1'b0};
    tbl[4] = '{16'hED20, 4, 1'b0, 16'h0000,    0, 4, 1'b1};
    tbl[5] = '{16'h00C3, 2, 1'b1, 16'h0009,    9, 2, 1'b0};
    tbl[6] = '{16'h09AB, 3, 1'b1, 16'h0876,  876, 3, 1'b0};
    out_ready = 1'b1;
    for (int f = 0; f < 7; f++) begin
      for (int j = 0; j < tbl[f].n; j++) begin
        logic [15:0] cw;
        cw = tbl[f].codes;
        send(cw[4*j +: 4], tbl[f].last_end && (j == tbl[f].n - 1));
        if (j < tbl[f].n - 1) chk($sformatf("tbl%0d_midvalid", f), out_valid, 0);
      end
      chk_result($sformatf("tbl%0d", f), tbl[f].bcd, tbl[f].bin, tbl[f].cnt, tbl[f].err);
      step();
      chk($sformatf("tbl%0d_pulse", f), out_valid, 0);
      chk($sformatf("tbl%0d_rdy", f), in_ready, 1);
    end
    out_ready = 1'b0;

    // auto-close, then a digit presented during OUT waits for the handshake
    for (int j = 0; j < 4; j++) send(4'hC, 1'b0);
    chk_result("auto", 16'h9999, 9999, 4, 1'b0);
    in_valid = 1'b1; in_code = 4'h3; in_last = 1'b1;
    step();
    chk("auto_hold_ready", in_ready, 0);
    chk("auto_hold_bcd", out_bcd, 16'h9999);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("auto_hs_valid", out_valid, 0);
    chk("auto_hs_ready", in_ready, 1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk_result("auto_next", 16'h0000, 0, 1, 1'b0);
    handshake("auto_next");

    // backpressure with a pending digit
    send(4'h4, 1'b1);
    in_valid = 1'b1; in_code = 4'h9; in_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_bcd", out_bcd, 16'h0001);
      chk("bp_bin", out_bin, 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    send(4'h3, 1'b1);
    chk_result("bp_next", 16'h0060, 60, 2, 1'b0);
    handshake("bp_next");

    // reset mid-frame
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_bcd", out_bcd, 0);
    chk("mid_rst_bin", out_bin, 0);
    chk("mid_rst_cnt", out_count, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_valid", out_valid, 0);
    rst_n = 1'b1;
    step();
    send(4'h3, 1'b1);
    chk_result("mid_rst_next", 16'h0000, 0, 1, 1'b0);
    handshake("mid_rst_next");

    // reset while holding a result
    send(4'h4, 1'b1);
    chk("out_rst_pre", out_valid, 1);
    rst_n = 1'b0;
    step();
    chk("out_rst_valid", out_valid, 0);
    chk("out_rst_ready", in_ready, 0);
    chk("out_rst_err", out_err, 0);
    rst_n = 1'b1;
    step();
    chk("out_rst_rel", in_ready, 1);
    chk("out_rst_rel_valid", out_valid, 0);

    // randomized run against the reference model
    m_digits.delete();
    m_err = 1'b0; m_acc = 1'b1; m_rdy = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      logic v, l, r, legal;
      logic [3:0] code;
      v    = ($urandom_range(0, 3) != 0);
      code = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(3, 12));
      l    = ($urandom_range(0, 3) == 0);
      r    = ($urandom_range(0, 1) == 1);
      in_valid = v; in_code = code; in_last = l; out_ready = r;
      if (m_acc) begin
        if (v && m_rdy) begin
          legal = (code >= 3) && (code <= 12);
          m_digits.push_back(legal ? int'(code) - 3 : 0);
          if (!legal) m_err = 1'b1;
          if (l || m_digits.size() == DIGITS) m_acc = 1'b0;
        end
      end else if (r) begin
        m_digits.delete();
        m_err = 1'b0;
        m_acc = 1'b1;
      end
      m_rdy = m_acc;
      step();
      chk("rnd_valid", out_valid, !m_acc);
      chk("rnd_ready", in_ready, m_rdy);
      if (!m_acc) begin
        chk("rnd_bcd", out_bcd, m_bcd());
        chk("rnd_bin", out_bin, m_bin());
        chk("rnd_cnt", out_count, m_digits.size());
        chk("rnd_err", out_err, m_err);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
